conv_win_asm: RTL
=================

CONV_WIN_ASM -- requirements
Module: conv_win_asm

Interface
REQ-001 SHALL have port clk, input, 1, the sole clock; all state updates on its rising edge.
REQ-002 SHALL have port arst_n, input, 1, reset that is asynchronous and active-low.
REQ-003 SHALL have port in_vld_i, input, 1, column beat valid.
REQ-004 SHALL have port in_rdy_o, output, 1, column beat accepted when in_vld_i & in_rdy_o.
REQ-005 SHALL have port in_col_i, input, conv_pkg::col_t, one column of 3 vertically adjacent pixels; [0]=oldest row, [2]=current row.
REQ-006 SHALL have port in_sol_i, input, 1, beat is the first column of a line.
REQ-007 SHALL have port in_eol_i, input, 1, beat is the last column of a line.
REQ-008 SHALL have port out_vld_o, output, 1, window valid.
REQ-009 SHALL have port out_rdy_i, input, 1, downstream kernel accepts the window.
REQ-010 SHALL have port out_win_o, output, conv_pkg::win_t, 3x3 window; [0]=left, [1]=centre, [2]=right column.
REQ-011 SHALL have port out_sol_o, output, 1, first window of a line.
REQ-012 SHALL have port out_eol_o, output, 1, last window of a line.

Function
REQ-013 SHALL hold two column registers: P (column k-2) and Q (column k-1).
REQ-014 SHALL implement states IDLE, PRIME, RUN and FLUSH.
REQ-015 SHALL drive in_rdy_o = (state != FLUSH) & (!out_vld_o | out_rdy_i); the combinational path from out_rdy_i is permitted.
REQ-016 SHALL, on an accepted sol beat without eol, in any state: load P and Q with in_col_i; set sol_pend; go to PRIME; produce no window; discard any partial line.
REQ-017 SHALL, on an accepted non-sol, non-eol beat x in PRIME or RUN, register out_win_o = {P,Q,x} with out_vld_o=1 on the next cycle, shift P<=Q and Q<=x, and go to RUN.
REQ-018 SHALL set out_sol_o=sol_pend on the window produced per REQ-017, REQ-019 or REQ-021, and clear sol_pend when that window is produced.
REQ-019 SHALL, on an accepted eol beat x (non-sol) in PRIME or RUN, register window {P,Q,x} with out_eol_o=0, shift P<=Q and Q<=x, and go to FLUSH.
REQ-020 SHALL, in FLUSH when !out_vld_o | out_rdy_i, register window {P,Q,Q} (right-edge replication) with out_eol_o=1, then go to IDLE.
REQ-021 SHALL, on an accepted beat with sol & eol (width-1 line), load P=Q=x, set sol_pend, and go to FLUSH; the flush then emits {x,x,x} with out_sol_o=out_eol_o=1.
REQ-022 SHALL, in IDLE, accept non-sol beats and discard them without output.
REQ-023 SHALL hold out_win_o, out_sol_o and out_eol_o stable while out_vld_o & !out_rdy_i.
REQ-024 SHALL clear out_vld_o on out_rdy_i when no new window is produced that cycle.
REQ-025 SHALL produce exactly W windows for a line of W columns: window latency is 1 cycle after the right-neighbour column is accepted, with one input bubble per line (the FLUSH cycle).
REQ-026 SHALL implement left-edge replication implicitly via REQ-016 (the first window is {x0,x0,x1}).

Reset
REQ-027 SHALL, on assertion of arst_n=0, force state=IDLE and out_vld_o=0, and clear sol_pend; P, Q and the window data registers are non-reset.
REQ-028 SHALL, on deassertion of reset, present out_sol_o=out_eol_o=0 and in_rdy_o=1.
REQ-029 SHALL, on reset asserted mid-line, abandon the line; the next useful input is a sol beat.

Structure
REQ-030 SHALL take col_t (3 x pixel_t), win_t (3 x col_t) and KERNEL_N=3 from conv_pkg.
REQ-031 SHALL be a single module with no sub-module; the FSM and the output register slice are local.

Verification
REQ-032 SHALL cover: a W=4 line with columns 10,20,30,40 and out_rdy_i=1 -> windows {10,10,20}(sol), {10,20,30}, {20,30,40}, {30,40,40}(eol), with in_rdy_o low for exactly 1 cycle.
REQ-033 SHALL cover: a width-1 line with column 7 (sol & eol) -> a single window {7,7,7} with out_sol_o=out_eol_o=1.
REQ-034 SHALL cover: out_rdy_i held 0 for 5 cycles mid-line -> window held stable, in_rdy_o=0, no beats lost, and the sequence matches the REQ-032 pattern.
REQ-035 SHALL cover: sol at column 3 of an unfinished line, then the new line 1,2 (eol) -> no flush of the old line; windows {1,1,2}(sol) and {1,2,2}(eol).
REQ-036 SHALL cover: 3 non-sol beats in IDLE -> all accepted and no window produced.
REQ-037 SHALL cover: arst_n pulsed low during RUN -> out_vld_o=0 immediately; a subsequent W=2 line 5,6 yields {5,5,6} and {5,6,6}.

Source files
------------

// File: rtl/conv_pkg.sv
// Shared types for the 3x3 convolution window assembler: pixel, column and window.
package conv_pkg;
  localparam int KERNEL_N = 3;
  localparam int PIX_W    = 8;

  typedef logic [PIX_W-1:0]      pixel_t;
  typedef pixel_t [KERNEL_N-1:0] col_t;   // [0]=oldest row, [2]=current row
  typedef col_t   [KERNEL_N-1:0] win_t;   // [0]=left, [1]=centre, [2]=right

  typedef enum logic [1:0] {ST_IDLE, ST_PRIME, ST_RUN, ST_FLUSH} state_t;

  function automatic win_t mk_win(input col_t l, input col_t c, input col_t r);
    win_t w;
    w[0] = l;
    w[1] = c;
    w[2] = r;
    return w;
  endfunction
endpackage

// File: rtl/conv_win_asm.sv
// Assembles a stream of pixel columns into 3x3 windows with left/right edge
// replication; one registered output slice with valid/ready backpressure.
module conv_win_asm
  import conv_pkg::*;
(
  input  logic   clk,
  input  logic   arst_n,
  input  logic   in_vld_i,
  output logic   in_rdy_o,
  input  col_t   in_col_i,
  input  logic   in_sol_i,
  input  logic   in_eol_i,
  output logic   out_vld_o,
  input  logic   out_rdy_i,
  output win_t   out_win_o,
  output logic   out_sol_o,
  output logic   out_eol_o
);

  state_t r_state;
  logic   r_vld, r_sol, r_eol, r_sol_pend;
  col_t   r_p, r_q;
  win_t   r_win;

  logic w_adv, w_acc, w_live, w_beat_win, w_flush_win, w_new_win, w_sol_acc;

  assign w_adv       = !r_vld | out_rdy_i;
  assign in_rdy_o    = (r_state != ST_FLUSH) & w_adv;
  assign w_acc       = in_vld_i & in_rdy_o;
  assign w_sol_acc   = w_acc & in_sol_i;
  assign w_live      = (r_state == ST_PRIME) | (r_state == ST_RUN);
  assign w_beat_win  = w_acc & !in_sol_i & w_live;
  assign w_flush_win = (r_state == ST_FLUSH) & w_adv;
  assign w_new_win   = w_beat_win | w_flush_win;

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      r_state    <= ST_IDLE;
      r_vld      <= 1'b0;
      r_sol      <= 1'b0;
      r_eol      <= 1'b0;
      r_sol_pend <= 1'b0;
    end else begin
      if (w_adv) r_vld <= w_new_win;
      if (w_new_win) begin
        r_sol      <= r_sol_pend;
        r_eol      <= w_flush_win;
        r_sol_pend <= 1'b0;
      end
      // A sol beat restarts the line from any state; a pending partial line is dropped.
      if (w_sol_acc) begin
        r_sol_pend <= 1'b1;
        r_state    <= in_eol_i ? ST_FLUSH : ST_PRIME;
      end else if (w_beat_win) begin
        r_state    <= in_eol_i ? ST_FLUSH : ST_RUN;
      end else if (w_flush_win) begin
        r_state    <= ST_IDLE;
      end
    end
  end

  // Datapath carries no reset: validity is owned entirely by r_vld / r_state.
  always_ff @(posedge clk) begin
    if (w_new_win)
      r_win <= mk_win(r_p, r_q, w_beat_win ? in_col_i : r_q);
    if (w_sol_acc) begin
      r_p <= in_col_i;
      r_q <= in_col_i;
    end else if (w_beat_win) begin
      r_p <= r_q;
      r_q <= in_col_i;
    end
  end

  assign out_vld_o = r_vld;
  assign out_win_o = r_win;
  assign out_sol_o = r_sol;
  assign out_eol_o = r_eol;

endmodule
